// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial adder/subtractor with start/busy/done handshake
module serial_adder_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         v,
    output logic         busy,
    output logic         done
);
    localparam int KW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  ra, rb, rs, rs_nx;
    logic [KW-1:0] k;
    logic          c, c_nx, sum, last, accept;

    assign sum    = ra[0] ^ rb[0] ^ c;
    assign c_nx   = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    assign rs_nx  = {sum, rs[N-1:1]};
    assign last   = k == KW'(N - 1);
    assign accept = start && state != RUN;
    assign busy   = state == RUN;
    assign done   = state == FIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            k     <= '0;
            c     <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            v     <= 1'b0;
        end else if (accept) begin
            ra    <= a;
            rb    <= sub ? ~b : b;
            c     <= sub | cin;
            k     <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            ra <= ra >> 1;
            rb <= rb >> 1;
            rs <= rs_nx;
            c  <= c_nx;
            k  <= k + 1'b1;
            // c here is the carry into the MSB on the final step
            if (last) begin
                state <= FIN;
                s     <= rs_nx;
                cout  <= c_nx;
                v     <= c ^ c_nx;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed self-checking bench for serial_adder_n at N=8
module tb_serial_adder_n;
    logic       clk = 1'b0;
    logic       rst_n, start, sub, cin;
    logic [7:0] a, b, s;
    logic       cout, v, busy, done;
    int         tests = 0, fails = 0;
    int         j, nd;
    logic [7:0] ra_, rb_, bx;
    logic [8:0] r9;
    logic       rs_, rc_, rv_;

    serial_adder_n #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .s(s), .cout(cout), .v(v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sb, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ci, input logic [7:0] es, input logic ec, input logic ev,
                          input bit mess);
        int n, nb;
        @(negedge clk);
        start = 1'b1; sub = sb; a = aa; b = bb; cin = ci;
        @(negedge clk);
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (mess) begin
                start = 1'($urandom); sub = 1'($urandom); cin = 1'($urandom);
                a = 8'($urandom); b = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, n, 8);
        check({tag, " busy cycles"}, nb, 8);
        check({tag, " busy with done"}, busy, 0);
        check({tag, " s"}, s, es);
        check({tag, " cout"}, cout, ec);
        check({tag, " v"}, v, ev);
        @(negedge clk);
        check({tag, " done pulse width"}, done, 0);
        check({tag, " s held"}, s, es);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {s, cout, v, busy, done}, 0);
        rst_n = 1'b1;

        run_op("5a+3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
        run_op("ff+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("00+00+c", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
        run_op("10-20", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
        run_op("80-01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0);
        run_op("interference", 1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1);

        // back-to-back operation with start held high
        @(negedge clk);
        start = 1'b1; sub = 1'b0; cin = 1'b0; a = 8'h01; b = 8'h02;
        j = 0;
        while (!done && j < 40) begin @(negedge clk); j++; end
        check("held first latency", j, 9);
        for (int r = 0; r < 2; r++) begin
            j = 0;
            do begin
                @(negedge clk); j++;
                if (!done) check("held s stable", s, 8'h03);
            end while (!done && j < 40);
            check("held period", j, 9);
            check("held s", s, 8'h03);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // abort mid-run with asynchronous reset
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", {s, cout, v, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin @(negedge clk); if (done) nd++; end
        check("no done after abort", nd, 0);
        run_op("01+01 after reset", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            ra_ = 8'($urandom); rb_ = 8'($urandom); rs_ = 1'($urandom); rc_ = 1'($urandom);
            bx  = rs_ ? ~rb_ : rb_;
            r9  = {1'b0, ra_} + {1'b0, bx} + {8'd0, rs_ | rc_};
            rv_ = (ra_[7] == bx[7]) && (r9[7] != ra_[7]);
            run_op($sformatf("rand%0d", i), rs_, ra_, rb_, rc_, r9[7:0], r9[8], rv_, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
